// File: rtl/register_write_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : register_write_sequencer_if
// Description : Requester handshake and register-store write bus of the
//               register write sequencer.
// Revision    : 1.0
// ============================================================================
interface register_write_sequencer_if;
  logic       req0_valid_i;
  logic [7:0] req0_id_i;
  logic [7:0] req0_value_i;
  logic       req0_ready_o;
  logic       req1_valid_i;
  logic [7:0] req1_id_i;
  logic [7:0] req1_value_i;
  logic       req1_ready_o;
  logic       sleep_i;
  logic [7:0] write_register_id_o;
  logic [7:0] write_register_value_o;
  logic       write_enable_o;
  logic       busy_o;
  logic       dropped_o;

  modport master (
    output req0_valid_i, req0_id_i, req0_value_i,
    output req1_valid_i, req1_id_i, req1_value_i,
    output sleep_i,
    input  req0_ready_o, req1_ready_o,
    input  write_register_id_o, write_register_value_o, write_enable_o,
    input  busy_o, dropped_o
  );

  modport slave (
    input  req0_valid_i, req0_id_i, req0_value_i,
    input  req1_valid_i, req1_id_i, req1_value_i,
    input  sleep_i,
    output req0_ready_o, req1_ready_o,
    output write_register_id_o, write_register_value_o, write_enable_o,
    output busy_o, dropped_o
  );
endinterface
`default_nettype wire

// File: rtl/register_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : register_write_sequencer
// Description : Arbitrates two register-write requesters and sequences single,
//               broadcast-expanded or dropped writes into the register store.
// Revision    : 1.0
// ============================================================================
module register_write_sequencer #(
  parameter logic [7:0] LED_BASE     = 8'h06,
  parameter logic [7:0] ALL_LED_BASE = 8'hFA,
  parameter logic [7:0] PRESCALE_ID  = 8'hFE
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  register_write_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    EXPAND = 2'd2,
    DROP   = 2'd3
  } state_t;

  state_t     state, state_next;
  logic [3:0] step, step_next;
  logic       last_grant;
  logic       grant;
  logic       ready0, ready1, accept;
  logic [7:0] sel_id, sel_value, sel_offset;
  logic [7:0] cap_id, cap_value, cap_offset;
  logic       we;
  logic [7:0] wid, wvalue;
  logic       dropped;

  // Round-robin: on a tie the requester not served last wins.
  always_comb begin
    if (bus.req0_valid_i && bus.req1_valid_i) grant = ~last_grant;
    else                                      grant = bus.req1_valid_i;
  end

  assign ready0     = (state == IDLE) && !rst_i && bus.req0_valid_i && !grant;
  assign ready1     = (state == IDLE) && !rst_i && bus.req1_valid_i &&  grant;
  assign accept     = ready0 || ready1;
  assign sel_id     = grant ? bus.req1_id_i    : bus.req0_id_i;
  assign sel_value  = grant ? bus.req1_value_i : bus.req0_value_i;
  assign sel_offset = sel_id - ALL_LED_BASE;
  assign cap_offset = cap_id - ALL_LED_BASE;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      step       <= 4'd0;
      last_grant <= 1'b1;
      cap_id     <= 8'd0;
      cap_value  <= 8'd0;
    end else begin
      state <= state_next;
      step  <= step_next;
      if (accept) begin
        last_grant <= grant;
        cap_id     <= sel_id;
        cap_value  <= sel_value;
      end
    end
  end

  always_comb begin
    state_next = state;
    step_next  = step;
    we         = 1'b0;
    wid        = 8'd0;
    wvalue     = 8'd0;
    dropped    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          // Classification uses the values being captured on this edge.
          if (sel_offset[7:2] == 6'd0)                   state_next = EXPAND;
          else if (sel_id == PRESCALE_ID && !bus.sleep_i) state_next = DROP;
          else                                           state_next = WRITE;
        end
      end
      WRITE: begin
        we         = 1'b1;
        wid        = cap_id;
        wvalue     = cap_value;
        state_next = IDLE;
      end
      EXPAND: begin
        // Per-LED registers are 4 apart; k picks ON_L/ON_H/OFF_L/OFF_H.
        we        = 1'b1;
        wid       = LED_BASE + {2'b00, step, cap_offset[1:0]};
        wvalue    = cap_value;
        step_next = step + 4'd1;
        if (step == 4'hF) state_next = IDLE;
      end
      DROP: begin
        dropped    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.req0_ready_o           = ready0;
  assign bus.req1_ready_o           = ready1;
  assign bus.write_enable_o         = we;
  assign bus.write_register_id_o    = wid;
  assign bus.write_register_value_o = wvalue;
  assign bus.busy_o                 = (state != IDLE);
  assign bus.dropped_o              = dropped;

endmodule
`default_nettype wire

// File: tb/tb_register_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_write_sequencer
// Description : Self-checking bench: table vectors, corner sequences and
//               randomized traffic against a transaction-queue model.
// Revision    : 1.0
// ============================================================================
module tb_register_write_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_write_sequencer_if bus ();
  register_write_sequencer dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct packed {
    logic       we;
    logic [7:0] id;
    logic [7:0] val;
    logic       drop;
  } ent_t;

  typedef struct {
    logic       sel;
    logic [7:0] id;
    logic [7:0] val;
    logic       sleep;
    int         writes;
    logic [7:0] first_id;
    logic [7:0] last_id;
    int         drops;
    int         busy;
  } vec_t;

  ent_t q[$];
  logic m_last;
  int   checks = 0;
  int   errors = 0;

  logic       acc0, acc1, obs_we, obs_busy, seen_first;
  int         n_wr, n_drop, n_busy;
  logic [7:0] first_id, last_id, last_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One request becomes the list of bus cycles it must produce.
  task automatic model_accept(input logic [7:0] id, input logic [7:0] val, input logic slp);
    ent_t e;
    int   a;
    if (id >= 8'hFA && id <= 8'hFD) begin
      for (int n = 0; n < 16; n++) begin
        a = 6 + 4 * n + (int'(id) - 250);
        e.we = 1'b1; e.id = a[7:0]; e.val = val; e.drop = 1'b0;
        q.push_back(e);
      end
    end else if (id == 8'hFE && !slp) begin
      e.we = 1'b0; e.id = 8'd0; e.val = 8'd0; e.drop = 1'b1;
      q.push_back(e);
    end else begin
      e.we = 1'b1; e.id = id; e.val = val; e.drop = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic tick();
    ent_t e;
    logic busy_m, g, er0, er1;
    @(negedge clk);
    busy_m = (q.size() != 0);
    e = busy_m ? q[0] : '0;
    if (bus.req0_valid_i && bus.req1_valid_i) g = ~m_last;
    else                                      g = bus.req1_valid_i;
    er0 = !rst && !busy_m && bus.req0_valid_i && !g;
    er1 = !rst && !busy_m && bus.req1_valid_i &&  g;
    chk("ready0",  bus.req0_ready_o, er0);
    chk("ready1",  bus.req1_ready_o, er1);
    chk("we",      bus.write_enable_o, e.we);
    chk("wid",     bus.write_register_id_o, e.id);
    chk("wval",    bus.write_register_value_o, e.val);
    chk("busy",    bus.busy_o, busy_m);
    chk("dropped", bus.dropped_o, e.drop);
    acc0 = bus.req0_ready_o; acc1 = bus.req1_ready_o;
    obs_we = bus.write_enable_o; obs_busy = bus.busy_o;
    if (bus.write_enable_o === 1'b1) begin
      n_wr++;
      if (!seen_first) first_id = bus.write_register_id_o;
      seen_first = 1'b1;
      last_id  = bus.write_register_id_o;
      last_val = bus.write_register_value_o;
    end
    if (bus.dropped_o === 1'b1) n_drop++;
    if (bus.busy_o === 1'b1) n_busy++;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_last = 1'b1;
    end else if (busy_m) begin
      void'(q.pop_front());
    end else if (er0 || er1) begin
      m_last = er1;
      if (er1) model_accept(bus.req1_id_i, bus.req1_value_i, bus.sleep_i);
      else     model_accept(bus.req0_id_i, bus.req0_value_i, bus.sleep_i);
    end
    #1;
  endtask

  task automatic clear_obs();
    n_wr = 0; n_drop = 0; n_busy = 0; seen_first = 1'b0;
    first_id = 8'd0; last_id = 8'd0; last_val = 8'd0;
  endtask

  function automatic logic [7:0] rand_id();
    case ($urandom_range(0, 4))
      0:       rand_id = 8'hFA + 8'($urandom_range(0, 3));
      1:       rand_id = 8'hFE;
      2:       rand_id = 8'hFF;
      default: rand_id = 8'($urandom_range(0, 255));
    endcase
  endfunction

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b0, 8'h06, 8'h55, 1'b0,  1, 8'h06, 8'h06, 0,  1};
    tbl[1] = '{1'b1, 8'hFB, 8'h10, 1'b0, 16, 8'h07, 8'h43, 0, 16};
    tbl[2] = '{1'b0, 8'hFE, 8'h1E, 1'b0,  0, 8'h00, 8'h00, 1,  1};
    tbl[3] = '{1'b0, 8'hFE, 8'h1E, 1'b1,  1, 8'hFE, 8'hFE, 0,  1};
    tbl[4] = '{1'b1, 8'hFF, 8'h33, 1'b0,  1, 8'hFF, 8'hFF, 0,  1};
    tbl[5] = '{1'b0, 8'hFA, 8'hAA, 1'b1, 16, 8'h06, 8'h42, 0, 16};
    tbl[6] = '{1'b1, 8'hFD, 8'h01, 1'b0, 16, 8'h09, 8'h45, 0, 16};
    tbl[7] = '{1'b0, 8'hF9, 8'h02, 1'b0,  1, 8'hF9, 8'hF9, 0,  1};

    rst = 1'b1;
    bus.req0_valid_i = 1'b0; bus.req0_id_i = 8'd0; bus.req0_value_i = 8'd0;
    bus.req1_valid_i = 1'b0; bus.req1_id_i = 8'd0; bus.req1_value_i = 8'd0;
    bus.sleep_i = 1'b0;
    m_last = 1'b1;
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    chk("reset_busy", obs_busy, 1'b0);
    chk("reset_we",   obs_we,   1'b0);

    // Table: one request each, run to completion, compare the totals.
    foreach (tbl[i]) begin
      int guard;
      bus.sleep_i = tbl[i].sleep;
      if (tbl[i].sel) begin
        bus.req1_valid_i = 1'b1; bus.req1_id_i = tbl[i].id; bus.req1_value_i = tbl[i].val;
      end else begin
        bus.req0_valid_i = 1'b1; bus.req0_id_i = tbl[i].id; bus.req0_value_i = tbl[i].val;
      end
      tick();
      chk($sformatf("v%0d_accept", i), tbl[i].sel ? acc1 : acc0, 1'b1);
      bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
      clear_obs();
      guard = 0;
      do begin
        tick();
        guard++;
      end while (obs_busy === 1'b1 && guard < 40);
      chk($sformatf("v%0d_timeout", i), guard < 40, 1'b1);
      chk($sformatf("v%0d_writes", i), n_wr, tbl[i].writes);
      chk($sformatf("v%0d_first", i), first_id, tbl[i].first_id);
      chk($sformatf("v%0d_last", i), last_id, tbl[i].last_id);
      chk($sformatf("v%0d_drops", i), n_drop, tbl[i].drops);
      chk($sformatf("v%0d_busy", i), n_busy, tbl[i].busy);
      if (tbl[i].writes > 0) chk($sformatf("v%0d_value", i), last_val, tbl[i].val);
    end

    // Tie after reset: req0 first; req0 re-requests so the next tie goes to req1.
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req0_valid_i = 1'b1; bus.req0_id_i = 8'h08; bus.req0_value_i = 8'h11;
    bus.req1_valid_i = 1'b1; bus.req1_id_i = 8'h09; bus.req1_value_i = 8'h22;
    tick();
    chk("tie1_r0", acc0, 1'b1);
    chk("tie1_r1", acc1, 1'b0);
    bus.req0_id_i = 8'h0A; bus.req0_value_i = 8'h33;
    clear_obs();
    tick();
    chk("tie1_write", last_id, 8'h08);
    tick();
    chk("tie2_r1", acc1, 1'b1);
    chk("tie2_r0", acc0, 1'b0);
    bus.req1_valid_i = 1'b0;
    tick();
    chk("tie2_write", last_id, 8'h09);
    chk("tie2_val",   last_val, 8'h22);
    tick();
    chk("tie3_r0", acc0, 1'b1);
    bus.req0_valid_i = 1'b0;
    tick(); tick();

    // Reset during EXPAND step 5 aborts the burst and restores req0 priority.
    bus.req1_valid_i = 1'b1; bus.req1_id_i = 8'hFB; bus.req1_value_i = 8'h10;
    tick();
    bus.req1_valid_i = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    clear_obs();
    tick();
    chk("rst_step5_id", last_id, 8'h1B);
    rst = 1'b0;
    clear_obs();
    tick();
    chk("rst_after_we",   obs_we,   1'b0);
    chk("rst_after_busy", obs_busy, 1'b0);
    repeat (3) tick();
    chk("rst_no_writes", n_wr, 0);
    bus.req0_valid_i = 1'b1; bus.req0_id_i = 8'h20; bus.req0_value_i = 8'h01;
    bus.req1_valid_i = 1'b1; bus.req1_id_i = 8'h21; bus.req1_value_i = 8'h02;
    tick();
    chk("rst_tie_r0", acc0, 1'b1);
    bus.req0_valid_i = 1'b0;
    tick(); tick();
    bus.req1_valid_i = 1'b0;
    tick(); tick();

    // Randomized traffic; requests held until accepted.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.sleep_i = 1'($urandom_range(0, 1));
      tick();
      if (acc0 || !bus.req0_valid_i) begin
        bus.req0_valid_i = 1'($urandom_range(0, 1));
        bus.req0_id_i = rand_id(); bus.req0_value_i = 8'($urandom_range(0, 255));
      end
      if (acc1 || !bus.req1_valid_i) begin
        bus.req1_valid_i = 1'($urandom_range(0, 1));
        bus.req1_id_i = rand_id(); bus.req1_value_i = 8'($urandom_range(0, 255));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
